// File: rtl/timers_axi_slave.sv
// timers_axi_slave: AXI4-Lite programmable down-counting timer with prescaler, auto-reload and level interrupt.
// Ports:
//   S_AXI_ACLK     single clock, rising edge
//   S_AXI_ARESET   asynchronous active-high reset
//   S_AXI_AW*/W*/B* AXI4-Lite write channels (AWPROT ignored)
//   S_AXI_AR*/R*   AXI4-Lite read channels (ARPROT ignored)
//   irq            level interrupt = STATUS.EXPIRED & CTRL.IRQ_EN
// Map: 0x00 CTRL{IRQ_EN,AUTO_RELOAD,EN}, 0x04 LOAD, 0x08 PRESCALE, 0x0C SCRATCH,
//      0x10 COUNT (RO), 0x14 STATUS{EXPIRED} (W1C), 0x18/0x1C SLVERR.
module timers_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    logic          aw_ready;
    logic          ar_ready;
    logic          b_valid;
    logic          r_valid;
    logic [1:0]    b_resp;
    logic [1:0]    r_resp;
    logic [DW-1:0] r_data;
    logic [DW-1:0] ctrl;
    logic [DW-1:0] load;
    logic [DW-1:0] prescale;
    logic [DW-1:0] scratch;
    logic [DW-1:0] count;
    logic [DW-1:0] presc_cnt;
    logic          status;
    logic [2:0]    w_idx;
    logic [2:0]    r_idx;
    logic          w_fire;
    logic          r_fire;
    logic          w_err;
    logic          r_err;
    logic          w_load;
    logic          st_clr;
    logic          tick;
    logic          expire;
    logic [DW-1:0] load_n;
    logic [DW-1:0] rd_mux;
    logic          unused;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] cur, input logic [DW-1:0] wd,
                                            input logic [SW-1:0] ws);
        logic [DW-1:0] r;
        r = cur;
        for (int i = 0; i < SW; i++)
            if (ws[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    // Word index only; byte offset bits are ignored. Indices 6 and 7 are unmapped.
    assign w_idx  = S_AXI_AWADDR[4:2];
    assign r_idx  = S_AXI_ARADDR[4:2];
    assign w_err  = w_idx[2] & w_idx[1];
    assign r_err  = r_idx[2] & r_idx[1];

    // The ready pulse is only raised while both valids are held, so the beat
    // completes in the cycle the pulse is high.
    assign w_fire = aw_ready & S_AXI_AWVALID & S_AXI_WVALID;
    assign r_fire = ar_ready & S_AXI_ARVALID;

    assign load_n = merge(load, S_AXI_WDATA, S_AXI_WSTRB);
    assign w_load = w_fire & (w_idx == 3'd1);
    assign st_clr = w_fire & (w_idx == 3'd5) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];

    assign tick   = ctrl[0] & (presc_cnt == prescale);
    assign expire = tick & (count == '0);

    assign irq    = status & ctrl[2];

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = aw_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RRESP   = r_resp;
    assign S_AXI_RDATA   = r_data;

    always_comb begin
        case (r_idx)
            3'd0:    rd_mux = ctrl;
            3'd1:    rd_mux = load;
            3'd2:    rd_mux = prescale;
            3'd3:    rd_mux = scratch;
            3'd4:    rd_mux = count;
            3'd5:    rd_mux = {{(DW-1){1'b0}}, status};
            default: rd_mux = '0;
        endcase
    end

    // Write channel: address and data are only taken together, and never while
    // a response is still outstanding.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_ready <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= 2'b00;
        end else begin
            aw_ready <= ~aw_ready & S_AXI_AWVALID & S_AXI_WVALID & ~b_valid;
            if (w_fire) begin
                b_valid <= 1'b1;
                b_resp  <= w_err ? 2'b10 : 2'b00;
            end else if (S_AXI_BREADY) begin
                b_valid <= 1'b0;
            end
        end
    end

    // Read channel: data is captured at acceptance and held until taken.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_resp   <= 2'b00;
            r_data   <= '0;
        end else begin
            ar_ready <= ~ar_ready & S_AXI_ARVALID & ~r_valid;
            if (r_fire) begin
                r_valid <= 1'b1;
                r_resp  <= r_err ? 2'b10 : 2'b00;
                r_data  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ctrl     <= '0;
            load     <= '0;
            prescale <= '0;
            scratch  <= '0;
        end else if (w_fire) begin
            case (w_idx)
                3'd0:    ctrl     <= merge(ctrl, S_AXI_WDATA, S_AXI_WSTRB);
                3'd1:    load     <= load_n;
                3'd2:    prescale <= merge(prescale, S_AXI_WDATA, S_AXI_WSTRB);
                3'd3:    scratch  <= merge(scratch, S_AXI_WDATA, S_AXI_WSTRB);
                default: ;
            endcase
        end
    end

    // Timer core. A LOAD write overrides whatever the tick would do to COUNT,
    // and a hardware expiry beats a same-cycle W1C of STATUS.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            presc_cnt <= '0;
            count     <= '0;
            status    <= 1'b0;
        end else begin
            presc_cnt <= (~ctrl[0] | tick) ? '0 : presc_cnt + 1'b1;
            if (w_load)
                count <= load_n;
            else if (tick)
                count <= (count != '0) ? count - 1'b1 : (ctrl[1] ? load : '0);
            status <= expire | (status & ~st_clr);
        end
    end
endmodule

// File: tb/tb_timers_axi_slave.sv
// tb_timers_axi_slave: randomized + directed scoreboard bench for timers_axi_slave.
module tb_timers_axi_slave;
    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [4:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        irq;

    int total = 0;
    int bad = 0;

    logic        rnd_rdy = 1'b0;
    logic        rdy_fixed = 1'b1;

    logic [1:0]  bq[$];
    rexp_t       rq[$];

    // Reference state: what each register should hold after the most recent edge.
    logic [31:0] m_ctrl, m_load, m_pre, m_scr, m_cnt, m_pc;
    logic        m_st;

    timers_axi_slave dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        bready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
        rready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Reference model. At each falling edge it sees the inputs and ready/valid
    // levels that the next rising edge will act on, queues the response that
    // an acceptance at that edge must produce, then advances its state.
    always @(negedge clk) begin : model
        logic        tick, wacc, racc, st_set, st_clr;
        logic [2:0]  wa, ra;
        logic [31:0] cnt_n, pc_n;
        rexp_t       re;
        if (rst) begin
            m_ctrl = '0; m_load = '0; m_pre = '0; m_scr = '0; m_cnt = '0; m_pc = '0; m_st = 1'b0;
            bq.delete();
            rq.delete();
        end else begin
            chk("irq", {31'b0, irq}, {31'b0, m_st & m_ctrl[2]});
            wacc = awready & awvalid & wvalid;
            racc = arready & arvalid;
            wa = awaddr[4:2];
            ra = araddr[4:2];
            if (racc) begin
                re.resp = (ra >= 3'd6) ? 2'b10 : 2'b00;
                case (ra)
                    3'd0: re.data = m_ctrl;
                    3'd1: re.data = m_load;
                    3'd2: re.data = m_pre;
                    3'd3: re.data = m_scr;
                    3'd4: re.data = m_cnt;
                    3'd5: re.data = {31'b0, m_st};
                    default: re.data = '0;
                endcase
                rq.push_back(re);
            end
            if (wacc) bq.push_back((wa >= 3'd6) ? 2'b10 : 2'b00);
            tick = m_ctrl[0] && (m_pc == m_pre);
            pc_n = (m_ctrl[0] && !tick) ? m_pc + 1 : 32'd0;
            cnt_n = m_cnt;
            st_set = 1'b0;
            st_clr = 1'b0;
            if (tick) begin
                if (m_cnt != 0) cnt_n = m_cnt - 1;
                else begin
                    st_set = 1'b1;
                    cnt_n = m_ctrl[1] ? m_load : 32'd0;
                end
            end
            if (wacc) begin
                case (wa)
                    3'd0: m_ctrl = bmerge(m_ctrl, wdata, wstrb);
                    3'd1: begin
                        m_load = bmerge(m_load, wdata, wstrb);
                        cnt_n = m_load;
                    end
                    3'd2: m_pre = bmerge(m_pre, wdata, wstrb);
                    3'd3: m_scr = bmerge(m_scr, wdata, wstrb);
                    3'd5: st_clr = wstrb[0] & wdata[0];
                    default: ;
                endcase
            end
            m_pc = pc_n;
            m_cnt = cnt_n;
            m_st = st_set | (m_st & ~st_clr);
        end
    end

    // Monitor: pops an expectation whenever the DUT completes a response.
    logic pbv = 1'b0, prv = 1'b0;
    always @(negedge clk) begin
        rexp_t e;
        if (rst) begin
            pbv = 1'b0;
            prv = 1'b0;
        end else begin
            if (pbv) chk("bvalid_after_handshake", {31'b0, bvalid}, 32'd0);
            if (prv) chk("rvalid_after_handshake", {31'b0, rvalid}, 32'd0);
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bresp_unexpected: got response %b, expected none", bresp);
                end else chk("bresp", {30'b0, bresp}, {30'b0, bq.pop_front()});
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rresp_unexpected: got data %h, expected none", rdata);
                end else begin
                    e = rq.pop_front();
                    chk("rresp", {30'b0, rresp}, {30'b0, e.resp});
                    chk("rdata", rdata, e.data);
                end
            end
            pbv = bvalid & bready;
            prv = rvalid & rready;
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!awready && n < 50);
        if (!awready) begin
            total++; bad++;
            $display("FAIL write_timeout: awready=0 after %0d cycles, expected 1", n);
        end else chk("wready_with_awready", {31'b0, wready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a);
        int n;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 50);
        if (!arready) begin
            total++; bad++;
            $display("FAIL read_timeout: arready=0 after %0d cycles, expected 1", n);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bq.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d outstanding responses, expected 0", bq.size() + rq.size());
        end
    endtask

    initial begin
        logic [2:0]  ai;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        int          op;

        repeat (3) @(negedge clk);
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_wready", {31'b0, wready}, 32'd0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_bresp", {30'b0, bresp}, 32'd0);
        chk("rst_rresp", {30'b0, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Register read-back
        for (int i = 0; i < 4; i++) axi_write(5'(4 * i), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) axi_read(5'(4 * i));
        drain();
        axi_write(5'h00, 32'h0, 4'hF);

        // Auto-reload with prescale 0
        axi_write(5'h08, 32'd0, 4'hF);
        axi_write(5'h04, 32'd3, 4'hF);
        axi_write(5'h00, 32'h7, 4'hF);
        for (int i = 0; i < 6; i++) begin
            axi_read(5'h10);
            axi_read(5'h14);
        end
        axi_write(5'h00, 32'h0, 4'hF);
        axi_write(5'h14, 32'h1, 4'h1);
        drain();

        // One-shot with prescale 2, interrupt disabled
        axi_write(5'h08, 32'd2, 4'hF);
        axi_write(5'h04, 32'd1, 4'hF);
        axi_write(5'h00, 32'h1, 4'hF);
        for (int i = 0; i < 8; i++) begin
            axi_read(5'h10);
            axi_read(5'h14);
        end
        chk("oneshot_irq", {31'b0, irq}, 32'd0);
        axi_write(5'h00, 32'h0, 4'hF);
        axi_write(5'h14, 32'h1, 4'h1);
        drain();

        // W1C racing an expiry: expiry every cycle, so the set must win
        axi_write(5'h04, 32'd0, 4'hF);
        axi_write(5'h08, 32'd0, 4'hF);
        axi_write(5'h00, 32'h7, 4'hF);
        axi_write(5'h14, 32'h1, 4'h1);
        axi_read(5'h14);
        axi_write(5'h00, 32'h4, 4'hF);
        axi_write(5'h14, 32'h1, 4'h1);
        axi_read(5'h14);
        drain();
        chk("irq_after_clear", {31'b0, irq}, 32'd0);

        // Unmapped addresses
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF);
        axi_read(5'h1C);
        for (int i = 0; i < 6; i++) axi_read(5'(4 * i));
        drain();

        // AWVALID without WVALID
        @(posedge clk); #1;
        awaddr = 5'h0C; wdata = 32'h31; wstrb = 4'hF; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("awready_alone", {31'b0, awready}, 32'd0);
            chk("wready_alone", {31'b0, wready}, 32'd0);
        end
        @(posedge clk); #1;
        wvalid = 1'b1;
        @(negedge clk);
        chk("awready_wvalid_rise", {31'b0, awready}, 32'd0);
        @(negedge clk);
        chk("awready_next", {31'b0, awready}, 32'd1);
        chk("wready_next", {31'b0, wready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        axi_read(5'h0C);
        drain();

        // Reset while a write response is pending
        rdy_fixed = 1'b0;
        @(posedge clk); #2;
        axi_write(5'h0C, 32'hA5A5, 4'hF);
        @(negedge clk);
        chk("bvalid_pending", {31'b0, bvalid}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("bvalid_async_rst", {31'b0, bvalid}, 32'd0);
        rdy_fixed = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        axi_write(5'h0C, 32'h55, 4'hF);
        axi_read(5'h0C);
        axi_read(5'h00);
        drain();

        // Randomized traffic with random back-pressure
        rnd_rdy = 1'b1;
        for (int k = 0; k < 250; k++) begin
            ai = 3'($urandom_range(0, 7));
            a = {ai, 2'($urandom_range(0, 3))};
            d = (ai == 3'd1) ? 32'($urandom_range(0, 6)) :
                (ai == 3'd2) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            s = 4'($urandom);
            op = $urandom_range(0, 2);
            if (op == 0) axi_write(a, d, s);
            else if (op == 1) axi_read(a);
            else fork
                axi_write(a, d, s);
                axi_read({3'($urandom_range(0, 7)), 2'b00});
            join
        end
        rnd_rdy = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/timers_axi_slave.md
TIMERS_AXI_SLAVE -- requirements
Module: timers_axi_slave

Interface
REQ-001 The module SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, giving the AXI4-Lite data width; only 32 is supported.
REQ-002 The module SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, giving the byte-address width.
REQ-003 The module SHALL have port S_AXI_ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port S_AXI_ARESET, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The module SHALL have the AXI4-Lite write-address ports S_AXI_AWADDR (in, C_S_AXI_ADDR_WIDTH), S_AXI_AWPROT (in, 3, ignored), S_AXI_AWVALID (in, 1) and S_AXI_AWREADY (out, 1).
REQ-006 The module SHALL have the write-data ports S_AXI_WDATA (in, 32), S_AXI_WSTRB (in, 4), S_AXI_WVALID (in, 1) and S_AXI_WREADY (out, 1).
REQ-007 The module SHALL have the write-response ports S_AXI_BRESP (out, 2), S_AXI_BVALID (out, 1) and S_AXI_BREADY (in, 1).
REQ-008 The module SHALL have the read-address ports S_AXI_ARADDR (in, C_S_AXI_ADDR_WIDTH), S_AXI_ARPROT (in, 3, ignored), S_AXI_ARVALID (in, 1) and S_AXI_ARREADY (out, 1).
REQ-009 The module SHALL have the read-data ports S_AXI_RDATA (out, 32), S_AXI_RRESP (out, 2), S_AXI_RVALID (out, 1) and S_AXI_RREADY (in, 1).
REQ-010 The module SHALL have port irq, output, 1 bit: level interrupt, asserted as STATUS[0] & CTRL[2].

Function
REQ-011 The register map SHALL be, with R/W registers storing all 32 bits for read-back:
- 0x00 CTRL R/W: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN.
- 0x04 LOAD R/W.
- 0x08 PRESCALE R/W.
- 0x0C SCRATCH R/W, no function.
- 0x10 COUNT RO.
- 0x14 STATUS: bit0 EXPIRED, W1C; bits 31:1 read 0.
REQ-012 Write acceptance: when AWVALID & WVALID & !BVALID, AWREADY and WREADY SHALL both pulse high for exactly one cycle; a single AWVALID or WVALID without the other SHALL NOT be accepted.
REQ-013 BVALID SHALL rise the cycle after acceptance and hold until the cycle BVALID & BREADY, then fall.
REQ-014 Read acceptance: when ARVALID & !RVALID, ARREADY SHALL pulse for one cycle; RVALID with RDATA SHALL follow the next cycle and hold stable until RVALID & RREADY.
REQ-015 Read and write channels SHALL operate independently; concurrent read and write in the same cycle SHALL both be accepted.
REQ-016 R/W registers SHALL apply WSTRB per byte; writes to COUNT SHALL be ignored, and a write to STATUS SHALL clear only bits written 1 with WSTRB[0]=1.
REQ-017 Addresses with AWADDR[4:2] or ARADDR[4:2] in 6..7 SHALL return SLVERR (2'b10), with writes discarded and RDATA=0; all other accesses SHALL return OKAY (2'b00); address bits [1:0] SHALL be ignored.
REQ-018 Prescaler: a 32-bit counter SHALL run while EN=1 and generate a one-cycle tick when it equals PRESCALE, then return to 0; with EN=0 it SHALL hold at 0.
REQ-019 On a tick with COUNT!=0, COUNT SHALL decrement by 1.
REQ-020 On a tick with COUNT==0, STATUS[0] SHALL set; COUNT SHALL reload to LOAD if AUTO_RELOAD=1, otherwise it SHALL stay 0 (one-shot, EN unchanged).
REQ-021 A write to LOAD SHALL also copy the strobed value into COUNT; this write SHALL take priority over a same-cycle tick.
REQ-022 When a hardware set and a W1C clear of STATUS[0] occur in the same cycle, the set SHALL win.
REQ-023 irq SHALL be combinational from the registered STATUS and CTRL bits, with no added latency.

Reset
REQ-024 While S_AXI_ARESET=1, the module SHALL asynchronously clear all registers, the prescaler, COUNT, STATUS, AWREADY, WREADY, BVALID, ARREADY, RVALID and irq; BRESP, RRESP and RDATA SHALL be 0.
REQ-025 Reset asserted mid-transaction SHALL abort it with no response issued; after release, the first handshake SHALL be accepted normally.

Verification
REQ-026 The bench SHALL check: write 1,2,3,4 to 0x00..0x0C, then read them back -> each returns the written value with OKAY, and BVALID/RVALID are each high for one cycle with BREADY/RREADY tied high.
REQ-027 The bench SHALL check: PRESCALE=0, LOAD=3, CTRL=0x7 -> COUNT goes 3,2,1,0 on consecutive cycles, STATUS[0]=1 and irq=1 on the tick at 0, then COUNT=3 on that same tick.
REQ-028 The bench SHALL check: PRESCALE=2, LOAD=1, CTRL=0x1 (one-shot) -> COUNT decrements every 3 cycles, STATUS[0] sets, COUNT holds 0, and irq stays 0.
REQ-029 The bench SHALL check: write 0x1 to STATUS on the same cycle as an expiry tick -> STATUS[0] reads 1; a later write of 0x1 -> reads 0 and irq deasserts.
REQ-030 The bench SHALL check: write to 0x18 and read 0x1C -> BRESP=RRESP=2'b10, RDATA=0, and no register changes.
REQ-031 The bench SHALL check: AWVALID alone for 5 cycles, then WVALID -> AWREADY=WREADY=0 until both are valid, and acceptance occurs in the cycle after WVALID rises.
